seq_div_16x8: RTL
=================

// Module: seq_div_16x8
// PURPOSE
//  Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
//  Inverse companion of the 8x8 approximate multiplier datapath; recovers operands/ratios from products.
//  One quotient bit per clock, valid/ready on both sides. Optional truncation (TRUNC) skips final iterations
//  for an approximate, lower-latency result, matching the team's approximate-arithmetic exploration.
// PARAMETERS
//  W      8  divisor/quotient/remainder width; dividend is 2W bits
//  TRUNC  0  number of final (LSB) iterations skipped; 0 = exact; legal 0..W-1
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    dividend/divisor valid
//  in_ready   out  1    block can accept operands (high only in IDLE)
//  dividend   in   2W   unsigned dividend, sampled on accept
//  divisor    in   W    unsigned divisor, sampled on accept
//  out_valid  out  1    result valid, held until out_ready
//  out_ready  in   1    consumer accepts result
//  quotient   out  W    unsigned quotient
//  remainder  out  W    unsigned remainder (0 when TRUNC>0)
//  ovf        out  1    quotient does not fit in W bits (dividend[2W-1:W] >= divisor, divisor != 0)
//  div_zero   out  1    divisor == 0
// BEHAVIOUR
//  - Reset (async): state=IDLE, out_valid=0, quotient=0, remainder=0, ovf=0, div_zero=0, iteration counter=0.
//    in_ready = (state==IDLE); operands ignored while rst high. Reset mid-operation aborts; no result emitted.
//  - States: IDLE -> CALC on accept (in_valid & in_ready) with normal operands; IDLE -> DONE on accept if
//    div_zero or ovf; CALC -> DONE when counter reaches W-TRUNC iterations; DONE -> IDLE on out_ready.
//  - Accept edge: latch divisor; P (W+1 bits) = {0,dividend[2W-1:W]}; low dividend bits into shift reg; cnt=0.
//  - CALC, one iteration/edge, MSB first: P' = {P[W-1:0], next dividend bit}; if P' >= divisor:
//    P = P'-divisor, qbit=1 else P = P', qbit=0; qbit shifted into quotient LSB; cnt++.
//  - Latency: out_valid rises W-TRUNC cycles after the accept edge (8 for defaults); special cases: 1 cycle.
//  - TRUNC>0: quotient = exact quotient with low TRUNC bits = 0 (quotient register left-shifted TRUNC);
//    remainder forced 0.
//  - div_zero: quotient={W{1}}, remainder=dividend[W-1:0], div_zero=1, ovf=0.
//  - ovf: quotient={W{1}}, remainder=0, ovf=1, div_zero=0.
//  - Normal result: ovf=div_zero=0. Flags/data registered, valid together with out_valid.
//  - DONE: outputs stable while out_valid & !out_ready; in_ready=0. Handshake clears out_valid next edge;
//    data/flag registers hold last value. No accept in the same cycle as output handshake (in_ready low in DONE).
//  - in_valid while busy: ignored, operands must be held by producer until in_ready.
// STRUCTURE
//  - Shared package: state enum {IDLE,CALC,DONE}; width constants W, 2W; counter width $clog2(W+1).
//  - Sub-module div_step: combinational one restoring iteration (P, dividend bit, divisor) -> (P_next, qbit).
//  - Top: FSM, counter, operand/shift registers, special-case detect, output registers.
// TESTING
//  - Exact: dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0, out_valid 8 cycles after accept.
//  - Exact: 16'h1234 / 8'h56 -> quotient=8'h36 (54), remainder=8'h10 (16).
//  - Overflow: 16'h5000 / 8'h20 -> ovf=1, quotient=8'hFF, remainder=0, out_valid 1 cycle after accept.
//  - Divide by zero: 16'h0042 / 0 -> div_zero=1, quotient=8'hFF, remainder=8'h42, 1-cycle latency.
//  - TRUNC=2: 1000/7 -> quotient=140 (8'h8C), remainder=0, out_valid 6 cycles after accept.
//  - Backpressure + reset: hold out_ready=0 for 5 cycles -> outputs/flags stable, in_ready=0; then assert rst
//    at iteration 4 of a new divide -> out_valid=0, all outputs 0, in_ready=1 after release, next divide exact.

Source files
------------

// File: rtl/seq_div_16x8_pkg.sv
// Shared constants for the sequential restoring divider: widths, counter sizing and FSM encoding.
package seq_div_16x8_pkg;

  localparam int unsigned DivW      = 8;
  localparam int unsigned DividendW = 2 * DivW;
  localparam int unsigned CntW      = $clog2(DivW + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  typedef struct packed {
    logic ovf;
    logic div_zero;
  } div_flags_t;

  // Classifies an operand pair that bypasses the iteration loop.
  function automatic div_flags_t classify(input logic [DivW-1:0] hi, input logic [DivW-1:0] dvsr);
    div_flags_t f;
    f.div_zero = (dvsr == '0);
    f.ovf      = !f.div_zero && (hi >= dvsr);
    return f;
  endfunction

endpackage

// File: rtl/seq_div_16x8_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module seq_div_16x8_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   p,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W:0]   p_next,
  output logic         qbit
);

  // Partial remainder is always below the divisor, so the extra top bit keeps the compare exact.
  logic [W+1:0] p_sh;
  logic [W+1:0] diff;

  assign p_sh = {p, din};
  assign diff = p_sh - {2'b00, divisor};

  always_comb begin
    if (p_sh >= {2'b00, divisor}) begin
      p_next = diff[W:0];
      qbit   = 1'b1;
    end else begin
      p_next = p_sh[W:0];
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div_16x8.sv
// Sequential restoring divider, 2W/W -> W quotient and remainder, one quotient bit per clock.
module seq_div_16x8
  import seq_div_16x8_pkg::*;
#(
  parameter int unsigned W     = DivW,
  parameter int unsigned TRUNC = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           div_zero
);

  localparam int unsigned CntWidth = $clog2(W + 1);
  localparam logic [CntWidth-1:0] NumIter = CntWidth'(W - TRUNC);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [W-1:0]        dvsr_q, dvsr_d;
  logic [W:0]          p_q, p_d;
  logic [W-1:0]        lo_q, lo_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [W-1:0]        quo_q, quo_d;
  logic [W-1:0]        rem_q, rem_d;
  logic                ovf_q, ovf_d;
  logic                dz_q, dz_d;

  logic       accept;
  logic       is_dz;
  logic       is_ovf;
  logic [W:0] p_next;
  logic       qbit;

  assign accept = in_valid && in_ready;
  assign is_dz  = (divisor == '0);
  assign is_ovf = !is_dz && (dividend[2*W-1:W] >= divisor);

  seq_div_16x8_step #(
    .W (W)
  ) u_step (
    .p       (p_q),
    .din     (lo_q[W-1]),
    .divisor (dvsr_q),
    .p_next  (p_next),
    .qbit    (qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvsr_d  = dvsr_q;
    p_d     = p_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          dvsr_d = divisor;
          p_d    = {1'b0, dividend[2*W-1:W]};
          lo_d   = dividend[W-1:0];
          cnt_d  = '0;
          acc_d  = '0;
          if (is_dz) begin
            state_d = StDone;
            quo_d   = '1;
            rem_d   = dividend[W-1:0];
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end else if (is_ovf) begin
            state_d = StDone;
            quo_d   = '1;
            rem_d   = '0;
            ovf_d   = 1'b1;
            dz_d    = 1'b0;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        p_d   = p_next;
        lo_d  = {lo_q[W-2:0], 1'b0};
        acc_d = {acc_q[W-2:0], qbit};
        cnt_d = cnt_q + CntWidth'(1);
        if (cnt_d == NumIter) begin
          state_d = StDone;
          // Skipped LSB iterations leave those quotient bits at zero.
          quo_d   = acc_d << TRUNC;
          rem_d   = (TRUNC != 0) ? '0 : p_next[W-1:0];
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      p_q     <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvsr_q  <= dvsr_d;
      p_q     <= p_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign div_zero  = dz_q;

endmodule
